// File: rtl/bus_demux_pkg.sv
// Shared types and helpers for the three-target load/store bus demultiplexer.
package bus_demux_pkg;

    // Number of real downstream targets; the fourth select code is unmapped.
    localparam int unsigned NUM_TGT   = 3;
    // Width of the target ID carried in the pending queue.
    localparam int unsigned ID_W      = 2;
    // Widest address the decode helper accepts; callers zero-extend into it.
    localparam int unsigned ADDR_MAX  = 64;

    typedef enum logic [1:0] {
        TGT0    = 2'd0,
        TGT1    = 2'd1,
        TGT2    = 2'd2,
        TGT_ERR = 2'd3
    } tgt_id_t;

    // Pull the 2-bit select field starting at sel_lsb and map it to a target ID.
    function automatic tgt_id_t decode_tgt(input logic [ADDR_MAX-1:0] addr,
                                           input int unsigned         sel_lsb);
        return tgt_id_t'(2'(addr >> sel_lsb));
    endfunction

    // One-hot strobe for a target ID; the unmapped ID selects nothing.
    function automatic logic [NUM_TGT-1:0] tgt_onehot(input tgt_id_t id);
        logic [NUM_TGT-1:0] mask;
        mask = '0;
        case (id)
            TGT0:    mask = 3'b001;
            TGT1:    mask = 3'b010;
            TGT2:    mask = 3'b100;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bus_demux3_id_fifo.sv
// In-order pending-transaction queue holding the target ID of every accepted request.
module id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DW-1:0]            head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Ignore a push into a full queue and a pop from an empty one.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Storage: cleared on reset so a stale ID can never reach the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy carries one extra bit so full and empty stay distinct.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Status flags and head-of-queue view.
    always_comb begin
        full  = (count == CW'(DEPTH));
        empty = (count == CW'(0));
        head  = mem[rd_ptr];
    end

endmodule

// File: rtl/bus_demux3.sv
// Single-initiator to three-target data-bus demultiplexer with an in-order response steering queue.
module bus_demux3
    import bus_demux_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned SEL_LSB = 28,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic              req_we,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic [2:0]        dn_valid,
    input  logic [2:0]        dn_ready,
    output logic [AWIDTH-1:0] dn_addr,
    output logic              dn_we,
    output logic [WIDTH-1:0]  dn_wdata,
    input  logic [2:0]        tgt_rsp_valid,
    input  logic [WIDTH-1:0]  tgt_rdata0,
    input  logic [WIDTH-1:0]  tgt_rdata1,
    input  logic [WIDTH-1:0]  tgt_rdata2,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              proto_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Request hold stage
    logic              hold_valid;
    tgt_id_t           hold_tgt;
    logic              hold_fire;
    tgt_id_t           req_tgt;
    logic              accept;
    logic              load_hold;

    // Pending queue
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [ID_W-1:0]   fifo_head;
    tgt_id_t           head_id;
    logic              can_push;

    // Response steering
    logic              pop;
    logic [2:0]        expect_mask;
    logic [2:0]        stray;
    logic [WIDTH-1:0]  sel_rdata;
    logic              sel_err;

    // Decode, downstream strobe and upstream acceptance.
    always_comb begin
        req_tgt   = decode_tgt(ADDR_MAX'(req_addr), SEL_LSB);
        dn_valid  = hold_valid ? tgt_onehot(hold_tgt) : 3'b000;
        hold_fire = |(dn_valid & dn_ready);
        // Full blocks acceptance even if a pop is happening, keeping response off the ready path.
        can_push  = (fifo_count < CW'(DEPTH)) && !fifo_full;
        req_ready = !reset && (!hold_valid || hold_fire) && can_push;
        accept    = req_valid && req_ready;
        // Unmapped requests only occupy a queue slot; they never reach a target.
        load_hold = accept && (req_tgt != TGT_ERR);
    end

    // Hold register valid/target: cleared on handshake, reloaded by a mapped accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_tgt   <= TGT0;
        end else if (load_hold) begin
            hold_valid <= 1'b1;
            hold_tgt   <= req_tgt;
        end else if (hold_fire) begin
            hold_valid <= 1'b0;
        end
    end

    // Forwarded payload: only changes on a mapped accept, so it is stable until handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dn_addr  <= '0;
            dn_we    <= 1'b0;
            dn_wdata <= '0;
        end else if (load_hold) begin
            dn_addr  <= req_addr;
            dn_we    <= req_we;
            dn_wdata <= req_wdata;
        end
    end

    id_fifo #(
        .DEPTH (DEPTH),
        .DW    (ID_W)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (ID_W'(req_tgt)),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Steer the head target's response back; an unmapped head is answered locally.
    always_comb begin
        pop         = 1'b0;
        expect_mask = 3'b000;
        sel_rdata   = '0;
        sel_err     = 1'b0;
        head_id     = tgt_id_t'(fifo_head);
        if (!fifo_empty) begin
            case (head_id)
                TGT0: begin
                    expect_mask = 3'b001;
                    pop         = tgt_rsp_valid[0];
                    sel_rdata   = tgt_rdata0;
                end
                TGT1: begin
                    expect_mask = 3'b010;
                    pop         = tgt_rsp_valid[1];
                    sel_rdata   = tgt_rdata1;
                end
                TGT2: begin
                    expect_mask = 3'b100;
                    pop         = tgt_rsp_valid[2];
                    sel_rdata   = tgt_rdata2;
                end
                default: begin
                    pop         = 1'b1;
                    sel_err     = 1'b1;
                end
            endcase
        end
        if (!pop) begin
            sel_rdata = '0;
        end
        // Any response not from the current head target is dropped and flagged.
        stray = tgt_rsp_valid & ~expect_mask;
    end

    // Registered response to the core, one pulse per popped transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= pop;
            rsp_rdata <= sel_rdata;
            rsp_err   <= sel_err;
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (|stray) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: doc/bus_demux3.md
# bus_demux3

Single-initiator to three-target data-bus demultiplexer for the core's load/store port: decodes each request address to one of three targets, forwards it through a one-entry registered request stage with valid/ready handshake, and records each target ID in an in-order pending queue. The queue steers the matching target's response back to the core. Unmapped addresses are answered locally with an error response. Sits between the memory stage and the RAM/peripheral targets.

## Interface

Parameters:
- WIDTH, 32, data width.
- AWIDTH, 32, address width.
- SEL_LSB, 28, LSB of the 2-bit target-select field `addr[SEL_LSB+1:SEL_LSB]`.
- DEPTH, 4, maximum outstanding transactions (power of two, ≥2).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  upstream request accepted when high with req_valid.
- req_addr  in  AWIDTH  request address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  WIDTH  store data.
- dn_valid  out  3  one-hot per-target request valid.
- dn_ready  in  3  per-target ready.
- dn_addr  out  AWIDTH  shared forwarded address.
- dn_we  out  1  shared forwarded write enable.
- dn_wdata  out  WIDTH  shared forwarded store data.
- tgt_rsp_valid  in  3  per-target response valid (single-cycle pulse).
- tgt_rdata0, tgt_rdata1, tgt_rdata2  in  WIDTH  per-target response data.
- rsp_valid  out  1  response to core (core always accepts).
- rsp_rdata  out  WIDTH  response data.
- rsp_err  out  1  decode-error response.
- proto_err  out  1  sticky protocol-violation flag.

## Operation

- Decode: sel = req_addr[SEL_LSB+1:SEL_LSB]. 00/01/10 map to targets 0/1/2; 11 is unmapped (ERR).
- Accept: req_ready = (!hold_valid || hold_fire) && (count < DEPTH). hold_fire = hold_valid && dn_ready[hold_tgt]. Every accepted request pushes its ID (0–2 or ERR) into the pending FIFO.
- Request stage:
  - A mapped request loads the hold register: addr, we, wdata, and target.
  - dn_valid[hold_tgt] = hold_valid. All other bits are 0.
  - Payload stays stable until hold_fire.
  - An ERR request never loads the hold register and never asserts any dn_valid.
- Response steering, with head ID h:
  - h = 0–2 and tgt_rsp_valid[h]: pop; register rsp_valid=1, rsp_rdata=tgt_rdata<h>, rsp_err=0.
  - h = ERR: pop in the cycle it is head; register rsp_valid=1, rsp_rdata=0, rsp_err=1.
  - tgt_rsp_valid[i] with i ≠ h, or any tgt_rsp_valid while the FIFO is empty: set proto_err. That response is dropped and the FIFO is unchanged.
  - An ERR head pops even if a stray tgt_rsp_valid arrives in the same cycle. The stray response still sets proto_err.
- Full: count = DEPTH forces req_ready=0, even when a pop occurs in the same cycle. This avoids a combinational path from response to ready.
- Simultaneous push and pop below full: count is unchanged.
- Reset, including mid-operation: the hold register, FIFO, and count are cleared. All in-flight transactions are discarded without a response. All outputs go to 0, proto_err included.

## Timing

- Reset values: req_ready=0 while reset is high and 1 the first cycle after, dn_valid=0, dn_addr/dn_we/dn_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, proto_err=0.
- Request path: accepted at edge N; dn_valid is high in cycle N+1. Back-to-back accepts are possible when the target is ready every cycle.
- Response path: tgt_rsp_valid[h] in cycle M gives rsp_valid in cycle M+1. It is a single-cycle pulse.
- ERR path: accepted at edge N into an empty FIFO gives rsp_valid/rsp_err in cycle N+2.
- Targets must respond no earlier than the cycle after dn_valid&dn_ready, and in acceptance order.

## Structure

- Package bus_demux_pkg:
  - typedef enum logic[1:0] tgt_id_t {TGT0, TGT1, TGT2, TGT_ERR}.
  - Function decode_tgt(addr) → tgt_id_t.
- Sub-module id_fifo: synchronous FIFO with parameters DEPTH and data width. Ports: push/pop/full/empty/count/head, async active-high reset. Pointers wrap modulo DEPTH, and count carries one extra bit so full and empty are distinguishable.
- Response selection inside bus_demux3 is a case on the head ID.

## Test plan

All scenarios use SEL_LSB=28 and DEPTH=4.

- Load addr 0x1000_0004, dn_ready=3'b111 → dn_valid=3'b010 and dn_addr=0x1000_0004 one cycle after accept. tgt_rsp_valid[1] with 0xDEADBEEF → next cycle rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store addr 0x3000_0000 → dn_valid stays 0. Two cycles after accept: rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Store to 0x0000_0010 wdata 0x1234_5678 with dn_ready[0]=0 for 5 cycles → dn_valid=3'b001 and payload stable all 5 cycles, req_ready=0. Handshake completes on the cycle dn_ready rises.
- Accept 4 requests to targets 0,1,2,0 with no responses → req_ready=0 on the 5th. tgt_rsp_valid[0] → pop, and req_ready=1 the following cycle.
- Outstanding T0 then T1; tgt_rsp_valid[1] first → proto_err=1 (sticky) and no rsp_valid. A later tgt_rsp_valid[0] returns 0xA5A5A5A5 on rsp_rdata.
- Assert reset with hold_valid=1 and 2 pending → dn_valid=0 and rsp_valid=0 immediately, count=0. req_ready=1 the first cycle after reset release.
